multicycle_controller: RTL and testbench

Control FSM for the KGP-RISC multicycle processor. Reads the instruction register output from the datapath and drives every load, select and enable strobe the datapath consumes, sequencing each instruction through IF/ID/EX/MEM/WB. It is the command side of the datapath control interface and adds a data-memory ready handshake and halt/illegal reporting.

---
 rtl/kgp_ctrl_pkg.sv | 43 ++++
 rtl/ctrl_decode.sv | 35 +++
 rtl/multicycle_controller.sv | 193 +++++++++++++++++++
 tb/tb_multicycle_controller.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kgp_ctrl_pkg.sv
// Shared constants and types for the KGP-RISC multicycle control FSM:
// opcodes, ALU/opcond encodings, FSM states and instruction classes.
package kgp_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h20;
  localparam logic [5:0] OP_SW    = 6'h21;
  localparam logic [5:0] OP_BEQZ  = 6'h30;
  localparam logic [5:0] OP_BNEZ  = 6'h31;
  localparam logic [5:0] OP_J     = 6'h32;
  localparam logic [5:0] OP_HALT  = 6'h3F;
  // Upper opcode bits shared by the whole 6'h10-6'h1F ALU-immediate group
  localparam logic [1:0] OP_ALUI_HI = 2'b01;

  localparam logic [3:0] ALU_ADD = 4'h0;

  localparam logic [1:0] OPCOND_NPC = 2'b00;
  localparam logic [1:0] OPCOND_EQZ = 2'b01;
  localparam logic [1:0] OPCOND_NEZ = 2'b10;
  localparam logic [1:0] OPCOND_ALU = 2'b11;

  typedef enum logic [2:0] {
    StIf,
    StId,
    StEx,
    StMem,
    StWb,
    StHalt
  } state_e;

  typedef enum logic [3:0] {
    ClsRtype,
    ClsAlui,
    ClsLoad,
    ClsStore,
    ClsBeqz,
    ClsBnez,
    ClsJump,
    ClsHalt,
    ClsIllegal
  } cls_e;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode classifier: maps ir[31:26] to an instruction class and
// extracts the ALU function (funct for R-type, opcode[3:0] for ALU-immediate).
module ctrl_decode
  import kgp_ctrl_pkg::*;
(
  input  logic [5:0] i_opcode,
  input  logic [3:0] i_funct,
  output cls_e       o_cls,
  output logic [3:0] o_alufunc
);

  always_comb begin
    o_cls     = ClsIllegal;
    o_alufunc = ALU_ADD;
    if (i_opcode[5:4] == OP_ALUI_HI) begin
      o_cls     = ClsAlui;
      o_alufunc = i_opcode[3:0];
    end else begin
      case (i_opcode)
        OP_RTYPE: begin
          o_cls     = ClsRtype;
          o_alufunc = i_funct;
        end
        OP_LW:   o_cls = ClsLoad;
        OP_SW:   o_cls = ClsStore;
        OP_BEQZ: o_cls = ClsBeqz;
        OP_BNEZ: o_cls = ClsBnez;
        OP_J:    o_cls = ClsJump;
        OP_HALT: o_cls = ClsHalt;
        default: o_cls = ClsIllegal;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_controller.sv
// KGP-RISC multicycle control FSM (IF/ID/EX/MEM/WB/HALT) with dmem ready handshake.
// Optional performance counters are enabled by defining CTRL_PERF_CNT_EN.
module multicycle_controller
  import kgp_ctrl_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_ir,
  input  logic        i_dmem_ready,
  output logic        o_readim,
  output logic        o_ldir,
  output logic        o_ldnpc,
  output logic        o_lda,
  output logic        o_ldb,
  output logic        o_ldimm,
  output logic        o_alusel1,
  output logic        o_alusel2,
  output logic [3:0]  o_alufunc,
  output logic        o_aluen,
  output logic        o_ldaluout,
  output logic        o_readdmem,
  output logic        o_writedmem,
  output logic        o_ldlmd,
  output logic [1:0]  o_opcond,
  output logic        o_branch,
  output logic        o_ldpc,
  output logic        o_regwrite,
  output logic        o_selwb,
  output logic        o_halted,
`ifdef CTRL_PERF_CNT_EN
  output logic [31:0] o_cyc_cnt,
  output logic [31:0] o_instr_cnt,
`endif
  output logic        o_illegal
);

  state_e     r_state;
  state_e     w_state_d;
  logic       r_illegal;
  cls_e       w_cls;
  logic [3:0] w_alufunc;
  logic       w_unused_ir;

  assign w_unused_ir = ^i_ir[25:4];

  ctrl_decode u_decode (
    .i_opcode  (i_ir[31:26]),
    .i_funct   (i_ir[3:0]),
    .o_cls     (w_cls),
    .o_alufunc (w_alufunc)
  );

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIf: w_state_d = StId;
      StId: begin
        if (w_cls == ClsHalt || w_cls == ClsIllegal) w_state_d = StHalt;
        else                                         w_state_d = StEx;
      end
      StEx: w_state_d = StMem;
      StMem: begin
        case (w_cls)
          ClsLoad:           if (i_dmem_ready) w_state_d = StWb;
          ClsStore:          if (i_dmem_ready) w_state_d = StIf;
          ClsRtype, ClsAlui: w_state_d = StWb;
          default:           w_state_d = StIf;
        endcase
      end
      StWb:    w_state_d = StIf;
      StHalt:  w_state_d = StHalt;
      default: w_state_d = StIf;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= StIf;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_state_d;
      if (r_state == StId && w_cls == ClsIllegal) r_illegal <= 1'b1;
    end
  end

  // Strobes are gated by reset so the datapath sees all zeros while reset is held
  always_comb begin
    o_readim    = 1'b0;
    o_ldir      = 1'b0;
    o_ldnpc     = 1'b0;
    o_lda       = 1'b0;
    o_ldb       = 1'b0;
    o_ldimm     = 1'b0;
    o_alusel1   = 1'b0;
    o_alusel2   = 1'b0;
    o_alufunc   = 4'h0;
    o_aluen     = 1'b0;
    o_ldaluout  = 1'b0;
    o_readdmem  = 1'b0;
    o_writedmem = 1'b0;
    o_ldlmd     = 1'b0;
    o_opcond    = OPCOND_NPC;
    o_branch    = 1'b0;
    o_ldpc      = 1'b0;
    o_regwrite  = 1'b0;
    o_selwb     = 1'b0;
    o_halted    = 1'b0;
    if (i_rst_n) begin
      case (r_state)
        StIf: begin
          o_readim = 1'b1;
          o_ldir   = 1'b1;
          o_ldnpc  = 1'b1;
        end
        StId: begin
          o_lda   = 1'b1;
          o_ldb   = 1'b1;
          o_ldimm = 1'b1;
        end
        StEx: begin
          o_aluen    = 1'b1;
          o_ldaluout = 1'b1;
          o_alufunc  = w_alufunc;
          case (w_cls)
            ClsRtype: o_alusel1 = 1'b1;
            ClsAlui, ClsLoad, ClsStore: begin
              o_alusel1 = 1'b1;
              o_alusel2 = 1'b1;
            end
            ClsBeqz, ClsBnez, ClsJump: o_alusel2 = 1'b1;
            default: ;
          endcase
        end
        StMem: begin
          case (w_cls)
            ClsLoad: begin
              o_readdmem = 1'b1;
              o_ldlmd    = i_dmem_ready;
              o_ldpc     = i_dmem_ready;
            end
            ClsStore: begin
              o_writedmem = 1'b1;
              o_ldpc      = i_dmem_ready;
            end
            ClsRtype, ClsAlui: o_ldpc = 1'b1;
            ClsBeqz: begin
              o_ldpc   = 1'b1;
              o_opcond = OPCOND_EQZ;
            end
            ClsBnez: begin
              o_ldpc   = 1'b1;
              o_opcond = OPCOND_NEZ;
            end
            ClsJump: begin
              o_ldpc   = 1'b1;
              o_branch = 1'b1;
            end
            default: ;
          endcase
        end
        StWb: begin
          o_regwrite = 1'b1;
          o_selwb    = (w_cls != ClsLoad);
        end
        StHalt:  o_halted = 1'b1;
        default: ;
      endcase
    end
  end

  assign o_illegal = r_illegal;

`ifdef CTRL_PERF_CNT_EN
  logic [31:0] r_cyc_cnt;
  logic [31:0] r_instr_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cyc_cnt   <= 32'd0;
      r_instr_cnt <= 32'd0;
    end else begin
      if (r_state != StHalt) r_cyc_cnt <= r_cyc_cnt + 32'd1;
      if ((r_state == StMem || r_state == StWb) && w_state_d == StIf) begin
        r_instr_cnt <= r_instr_cnt + 32'd1;
      end
    end
  end

  assign o_cyc_cnt   = r_cyc_cnt;
  assign o_instr_cnt = r_instr_cnt;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: per-cycle expected strobe vectors
// are queued with the stimulus and compared just after each falling edge.
module tb_multicycle_controller;

  typedef struct packed {
    logic       readim, ldir, ldnpc, lda, ldb, ldimm, alusel1, alusel2;
    logic [3:0] alufunc;
    logic       aluen, ldaluout, readdmem, writedmem, ldlmd;
    logic [1:0] opcond;
    logic       branch, ldpc, regwrite, selwb, halted, illegal;
  } outs_t;

  typedef struct {
    logic  rdy;
    outs_t exp;
  } sb_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] ir;
  logic        dmem_ready;
  outs_t       obs;
`ifdef CTRL_PERF_CNT_EN
  logic [31:0] cyc_cnt;
  logic [31:0] instr_cnt;
`endif

  int  n_checks = 0;
  int  n_errors = 0;
  sb_t sb[$];

  multicycle_controller dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_ir         (ir),
    .i_dmem_ready (dmem_ready),
    .o_readim     (obs.readim),
    .o_ldir       (obs.ldir),
    .o_ldnpc      (obs.ldnpc),
    .o_lda        (obs.lda),
    .o_ldb        (obs.ldb),
    .o_ldimm      (obs.ldimm),
    .o_alusel1    (obs.alusel1),
    .o_alusel2    (obs.alusel2),
    .o_alufunc    (obs.alufunc),
    .o_aluen      (obs.aluen),
    .o_ldaluout   (obs.ldaluout),
    .o_readdmem   (obs.readdmem),
    .o_writedmem  (obs.writedmem),
    .o_ldlmd      (obs.ldlmd),
    .o_opcond     (obs.opcond),
    .o_branch     (obs.branch),
    .o_ldpc       (obs.ldpc),
    .o_regwrite   (obs.regwrite),
    .o_selwb      (obs.selwb),
    .o_halted     (obs.halted),
`ifdef CTRL_PERF_CNT_EN
    .o_cyc_cnt    (cyc_cnt),
    .o_instr_cnt  (instr_cnt),
`endif
    .o_illegal    (obs.illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected-vector model, one function per FSM phase
  function automatic outs_t e_if();
    outs_t e = '0;
    e.readim = 1'b1; e.ldir = 1'b1; e.ldnpc = 1'b1;
    return e;
  endfunction

  function automatic outs_t e_id(input logic ill);
    outs_t e = '0;
    e.lda = 1'b1; e.ldb = 1'b1; e.ldimm = 1'b1; e.illegal = ill;
    return e;
  endfunction

  function automatic outs_t e_ex(input logic s1, input logic s2, input logic [3:0] f);
    outs_t e = '0;
    e.aluen = 1'b1; e.ldaluout = 1'b1; e.alusel1 = s1; e.alusel2 = s2; e.alufunc = f;
    return e;
  endfunction

  function automatic outs_t e_mem(input logic rd, input logic wr, input logic lmd,
                                  input logic [1:0] oc, input logic br, input logic pc);
    outs_t e = '0;
    e.readdmem = rd; e.writedmem = wr; e.ldlmd = lmd; e.opcond = oc; e.branch = br;
    e.ldpc = pc;
    return e;
  endfunction

  function automatic outs_t e_wb(input logic sel);
    outs_t e = '0;
    e.regwrite = 1'b1; e.selwb = sel;
    return e;
  endfunction

  function automatic outs_t e_halt(input logic ill);
    outs_t e = '0;
    e.halted = 1'b1; e.illegal = ill;
    return e;
  endfunction

  function automatic sb_t ent(input logic rdy, input outs_t exp);
    sb_t s;
    s.rdy = rdy; s.exp = exp;
    return s;
  endfunction

  // Leaves the bench just after a falling edge with the DUT in IF
  task automatic apply_reset();
    rst_n = 1'b0;
    dmem_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    ir = 32'h0;
    dmem_ready = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    n_checks++;
    if (obs !== outs_t'('0)) begin
      n_errors++;
      $display("FAIL reset_outputs: got %h want 0", obs);
    end
`ifdef CTRL_PERF_CNT_EN
    n_checks++;
    if (cyc_cnt !== 32'd0 || instr_cnt !== 32'd0) begin
      n_errors++;
      $display("FAIL reset_counters: got %0d/%0d want 0/0", cyc_cnt, instr_cnt);
    end
`endif
    @(negedge clk);
    dmem_ready = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_rtype();
    int cyc = 0;
    ir = {6'h00, 22'h12345, 4'h2};
    sb.push_back(ent(1'b0, e_if()));
    sb.push_back(ent(1'b1, e_id(1'b0)));
    sb.push_back(ent(1'b1, e_ex(1'b1, 1'b0, 4'h2)));
    sb.push_back(ent(1'b0, e_mem(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1)));
    sb.push_back(ent(1'b1, e_wb(1'b1)));
    while (sb.size() > 0) begin
      sb_t e = sb.pop_front();
      dmem_ready = e.rdy;
      #1;
      n_checks++;
      if (obs !== e.exp) begin
        n_errors++;
        $display("FAIL rtype cyc %0d: got %h want %h", cyc, obs, e.exp);
      end
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic test_alu_imm();
    int cyc = 0;
    ir = {6'h1B, 26'h3ABCDEF};
    sb.push_back(ent(1'b0, e_if()));
    sb.push_back(ent(1'b0, e_id(1'b0)));
    sb.push_back(ent(1'b0, e_ex(1'b1, 1'b1, 4'hB)));
    sb.push_back(ent(1'b0, e_mem(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1)));
    sb.push_back(ent(1'b0, e_wb(1'b1)));
    while (sb.size() > 0) begin
      sb_t e = sb.pop_front();
      dmem_ready = e.rdy;
      #1;
      n_checks++;
      if (obs !== e.exp) begin
        n_errors++;
        $display("FAIL alu_imm cyc %0d: got %h want %h", cyc, obs, e.exp);
      end
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic test_load();
    int cyc = 0;
    ir = {6'h20, 22'h0, 4'h7};
    sb.push_back(ent(1'b1, e_if()));
    sb.push_back(ent(1'b1, e_id(1'b0)));
    sb.push_back(ent(1'b1, e_ex(1'b1, 1'b1, 4'h0)));
    sb.push_back(ent(1'b0, e_mem(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0)));
    sb.push_back(ent(1'b0, e_mem(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0)));
    sb.push_back(ent(1'b1, e_mem(1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1)));
    sb.push_back(ent(1'b1, e_wb(1'b0)));
    while (sb.size() > 0) begin
      sb_t e = sb.pop_front();
      dmem_ready = e.rdy;
      #1;
      n_checks++;
      if (obs !== e.exp) begin
        n_errors++;
        $display("FAIL load cyc %0d: got %h want %h", cyc, obs, e.exp);
      end
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic test_store();
    int cyc = 0;
    ir = {6'h21, 26'h0000005};
    // Zero-wait store followed by a one-wait store
    sb.push_back(ent(1'b0, e_if()));
    sb.push_back(ent(1'b0, e_id(1'b0)));
    sb.push_back(ent(1'b0, e_ex(1'b1, 1'b1, 4'h0)));
    sb.push_back(ent(1'b1, e_mem(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1)));
    sb.push_back(ent(1'b1, e_if()));
    sb.push_back(ent(1'b1, e_id(1'b0)));
    sb.push_back(ent(1'b1, e_ex(1'b1, 1'b1, 4'h0)));
    sb.push_back(ent(1'b0, e_mem(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0)));
    sb.push_back(ent(1'b1, e_mem(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1)));
    while (sb.size() > 0) begin
      sb_t e = sb.pop_front();
      dmem_ready = e.rdy;
      #1;
      n_checks++;
      if (obs !== e.exp) begin
        n_errors++;
        $display("FAIL store cyc %0d: got %h want %h", cyc, obs, e.exp);
      end
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic test_branch();
    int cyc = 0;
    logic [5:0] ops [3];
    ops[0] = 6'h30;
    ops[1] = 6'h31;
    ops[2] = 6'h32;
    for (int k = 0; k < 3; k++) begin
      ir = {ops[k], 26'h1234567};
      sb.push_back(ent(1'b0, e_if()));
      sb.push_back(ent(1'b1, e_id(1'b0)));
      sb.push_back(ent(1'b0, e_ex(1'b0, 1'b1, 4'h0)));
      case (k)
        0:       sb.push_back(ent(1'b0, e_mem(1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b1)));
        1:       sb.push_back(ent(1'b1, e_mem(1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b1)));
        default: sb.push_back(ent(1'b0, e_mem(1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1)));
      endcase
      while (sb.size() > 0) begin
        sb_t e = sb.pop_front();
        dmem_ready = e.rdy;
        #1;
        n_checks++;
        if (obs !== e.exp) begin
          n_errors++;
          $display("FAIL branch op %h cyc %0d: got %h want %h", ops[k], cyc, obs, e.exp);
        end
        cyc++;
        @(negedge clk);
      end
    end
  endtask

  task automatic test_halt();
    int cyc = 0;
    ir = {6'h3F, 26'h0};
    sb.push_back(ent(1'b0, e_if()));
    sb.push_back(ent(1'b0, e_id(1'b0)));
    for (int i = 0; i < 100; i++) sb.push_back(ent(1'($urandom_range(0, 1)), e_halt(1'b0)));
    while (sb.size() > 0) begin
      sb_t e = sb.pop_front();
      dmem_ready = e.rdy;
      #1;
      n_checks++;
      if (obs !== e.exp) begin
        n_errors++;
        $display("FAIL halt cyc %0d: got %h want %h", cyc, obs, e.exp);
      end
      cyc++;
      @(negedge clk);
    end
    apply_reset();
  endtask

  task automatic test_illegal();
    int cyc = 0;
    ir = {6'h25, 26'h0};
    sb.push_back(ent(1'b0, e_if()));
    sb.push_back(ent(1'b0, e_id(1'b0)));
    for (int i = 0; i < 6; i++) sb.push_back(ent(1'b1, e_halt(1'b1)));
    while (sb.size() > 0) begin
      sb_t e = sb.pop_front();
      dmem_ready = e.rdy;
      #1;
      n_checks++;
      if (obs !== e.exp) begin
        n_errors++;
        $display("FAIL illegal cyc %0d: got %h want %h", cyc, obs, e.exp);
      end
      cyc++;
      @(negedge clk);
    end
    apply_reset();
    // Sticky flag must be cleared by reset and the FSM back in IF
    ir = {6'h00, 26'h0};
    #1;
    n_checks++;
    if (obs !== e_if()) begin
      n_errors++;
      $display("FAIL illegal_cleared: got %h want %h", obs, e_if());
    end
    @(negedge clk);
    apply_reset();
  endtask

  task automatic test_reset_mid_lw();
    int cyc = 0;
    ir = {6'h20, 26'h0};
    sb.push_back(ent(1'b0, e_if()));
    sb.push_back(ent(1'b0, e_id(1'b0)));
    sb.push_back(ent(1'b0, e_ex(1'b1, 1'b1, 4'h0)));
    sb.push_back(ent(1'b0, e_mem(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0)));
    sb.push_back(ent(1'b0, e_mem(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0)));
    while (sb.size() > 0) begin
      sb_t e = sb.pop_front();
      dmem_ready = e.rdy;
      #1;
      n_checks++;
      if (obs !== e.exp) begin
        n_errors++;
        $display("FAIL lw_wait cyc %0d: got %h want %h", cyc, obs, e.exp);
      end
      cyc++;
      @(negedge clk);
    end
    dmem_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (obs !== outs_t'('0)) begin
      n_errors++;
      $display("FAIL reset_mid_lw: got %h want 0", obs);
    end
`ifdef CTRL_PERF_CNT_EN
    n_checks++;
    if (cyc_cnt !== 32'd0 || instr_cnt !== 32'd0) begin
      n_errors++;
      $display("FAIL reset_mid_lw_counters: got %0d/%0d want 0/0", cyc_cnt, instr_cnt);
    end
`endif
    @(negedge clk);
    dmem_ready = 1'b0;
    rst_n = 1'b1;
    cyc = 0;
    ir = {6'h00, 22'h0, 4'h5};
    sb.push_back(ent(1'b0, e_if()));
    sb.push_back(ent(1'b0, e_id(1'b0)));
    sb.push_back(ent(1'b0, e_ex(1'b1, 1'b0, 4'h5)));
    sb.push_back(ent(1'b0, e_mem(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1)));
    sb.push_back(ent(1'b0, e_wb(1'b1)));
    sb.push_back(ent(1'b0, e_if()));
    while (sb.size() > 0) begin
      sb_t e = sb.pop_front();
      dmem_ready = e.rdy;
      #1;
      n_checks++;
      if (obs !== e.exp) begin
        n_errors++;
        $display("FAIL post_reset cyc %0d: got %h want %h", cyc, obs, e.exp);
      end
      cyc++;
      if (cyc < 6) @(negedge clk);
    end
`ifdef CTRL_PERF_CNT_EN
    n_checks++;
    if (instr_cnt !== 32'd1 || cyc_cnt !== 32'd5) begin
      n_errors++;
      $display("FAIL perf_counters: got instr %0d cyc %0d want 1 5", instr_cnt, cyc_cnt);
    end
`endif
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_alu_imm();
    test_load();
    test_store();
    test_branch();
    test_halt();
    test_illegal();
    test_reset_mid_lw();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
